// File: rtl/mem_pkg.sv
// Shared types and constants for the handshake memory controller.
package mem_pkg;

   localparam int RD_LAT_MIN     = 1;
   localparam int RD_LAT_MAX     = 2;
   localparam int PAR_DATA_W_MAX = 64;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Even parity: the stored bit makes the total number of ones even.
   function automatic logic evenParity(input logic [PAR_DATA_W_MAX-1:0] data);
      return ^data;
   endfunction

   function automatic int clampLat(input int lat);
      if (lat < RD_LAT_MIN) return RD_LAT_MIN;
      if (lat > RD_LAT_MAX) return RD_LAT_MAX;
      return lat;
   endfunction

endpackage

// File: rtl/mem_rsp_fifo.sv
// First-word-fall-through response buffer with an occupancy count.
// Head data reads as zero while empty so idle outputs stay at their reset value.
module mem_rsp_fifo
   import mem_pkg::*;
#(
   parameter int WIDTH = 9,
   parameter int DEPTH = 2
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_pushData,
   input  logic                     i_pop,
   output logic                     o_valid,
   output logic [WIDTH-1:0]         o_data,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [CNT_W-1:0] r_count;

   logic w_pop;
   logic w_push;
   logic w_full;

   assign w_full = (r_count == CNT_W'(DEPTH));
   assign w_pop  = i_pop && (r_count != '0);
   // A push into a full buffer is still legal when the head leaves in the same cycle.
   assign w_push = i_push && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= i_pushData;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_valid = (r_count != '0);
   assign o_data  = o_valid ? r_mem[r_rdPtr] : '0;
   assign o_count = r_count;

endmodule

// File: rtl/mem_hs_ctrl.sv
// Single-port memory behind valid/ready request and response channels.
// Optional feature macro: MEM_PARITY_EN (per-word even parity plus err_inj input).
module mem_hs_ctrl
   import mem_pkg::*;
#(
   parameter int                DATA_W    = 8,
   parameter int                ADDR_W    = 10,
   parameter int                DEPTH     = 1024,
   parameter int                RD_LAT    = 1,
   parameter int                RSP_DEPTH = 2,
   parameter logic [DATA_W-1:0] INIT_VAL  = '0
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              wr_rd,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wr_data,
`ifdef MEM_PARITY_EN
   input  logic              err_inj,
`endif
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              init_done
);

   localparam int                LAT      = clampLat(RD_LAT);
   localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int                CNT_W    = $clog2(RSP_DEPTH) + 1;
   localparam int                SUM_W    = CNT_W + 1;
   localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              err;
   } rsp_t;

   state_e            r_state;
   logic [IDX_W-1:0]  r_initAddr;
   logic [DATA_W-1:0] r_mem [DEPTH];
`ifdef MEM_PARITY_EN
   logic              r_par [DEPTH];
`endif

   rsp_t              r_pipe      [LAT];
   logic              r_pipeValid [LAT];

   logic              w_inRange;
   logic [IDX_W-1:0]  w_idx;
   logic              w_accept;
   logic              w_wrAcc;
   logic              w_rdAcc;
   rsp_t              w_rdRsp;
   logic [SUM_W-1:0]  w_inflight;
   logic [CNT_W-1:0]  w_fifoCount;
   logic              w_credit;
   logic              w_fifoValid;
   rsp_t              w_fifoHead;

   assign w_inRange = ({1'b0, addr} < DEPTH_A);
   assign w_idx     = addr[IDX_W-1:0];
   assign w_accept  = req_valid && req_ready;
   assign w_wrAcc   = w_accept && wr_rd && w_inRange;
   assign w_rdAcc   = w_accept && !wr_rd;

   // Clear sequence walks every implemented word once, then hands over to normal service.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_INIT;
         r_initAddr <= '0;
      end else if (r_state == ST_INIT) begin
         if (r_initAddr == LAST_IDX) begin
            r_state <= ST_RUN;
         end else begin
            r_initAddr <= r_initAddr + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == ST_INIT) begin
         r_mem[r_initAddr] <= INIT_VAL;
`ifdef MEM_PARITY_EN
         r_par[r_initAddr] <= evenParity(PAR_DATA_W_MAX'(INIT_VAL));
`endif
      end else if (w_wrAcc) begin
         r_mem[w_idx] <= wr_data;
`ifdef MEM_PARITY_EN
         r_par[w_idx] <= evenParity(PAR_DATA_W_MAX'(wr_data)) ^ err_inj;
`endif
      end
   end

   always_comb begin
      w_rdRsp = '0;
      if (w_inRange) begin
         w_rdRsp.data = r_mem[w_idx];
`ifdef MEM_PARITY_EN
         w_rdRsp.err  = (evenParity(PAR_DATA_W_MAX'(r_mem[w_idx])) != r_par[w_idx]);
`endif
      end else begin
         w_rdRsp.err  = 1'b1;
      end
   end

   // Stage 0 is the synchronous array read; later stages only add latency.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < LAT; i++) begin
            r_pipeValid[i] <= 1'b0;
            r_pipe[i]      <= '0;
         end
      end else begin
         r_pipeValid[0] <= w_rdAcc;
         r_pipe[0]      <= w_rdRsp;
         for (int i = 1; i < LAT; i++) begin
            r_pipeValid[i] <= r_pipeValid[i-1];
            r_pipe[i]      <= r_pipe[i-1];
         end
      end
   end

   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < LAT; i++) begin
         w_inflight = w_inflight + SUM_W'(r_pipeValid[i]);
      end
   end

   // Every read in flight owns a FIFO slot in advance, so the buffer can never overflow.
   assign w_credit  = ((SUM_W'(w_fifoCount) + w_inflight) < SUM_W'(RSP_DEPTH));
   assign req_ready = (r_state == ST_RUN) && w_credit;
   assign init_done = (r_state == ST_RUN);

   mem_rsp_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (RSP_DEPTH)
   ) u_rspFifo (
      .clk        (clk),
      .rst        (rst),
      .i_push     (r_pipeValid[LAT-1]),
      .i_pushData (r_pipe[LAT-1]),
      .i_pop      (rsp_ready),
      .o_valid    (w_fifoValid),
      .o_data     (w_fifoHead),
      .o_count    (w_fifoCount)
   );

   assign rsp_valid = w_fifoValid;
   assign rsp_data  = w_fifoHead.data;
   assign rsp_err   = w_fifoHead.err;

endmodule
